mult_accum_ctrl: RTL and testbench

MULT_ACCUM_CTRL -- requirements
Module: mult_accum_ctrl

---
 rtl/mult_accum_ctrl_pkg.sv | 6 +
 rtl/mult_accum_ctrl.sv | 61 ++++++
 tb/tb_mult_accum_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_accum_ctrl_pkg.sv
// mult_accum_ctrl_pkg: shared state encoding and default widths for the MAC burst controller
package mult_accum_ctrl_pkg;
  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 40;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
endpackage

// File: rtl/mult_accum_ctrl.sv
// mult_accum_ctrl: accumulates a burst of registered signed products and hands the sum downstream
module mult_accum_ctrl
  import mult_accum_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      C_NUM,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_num,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy
);
  state_t state, next_state;
  logic [LEN_W-1:0] cnt;
  logic [31:0] prod;
  logic [ACC_W-1:0] acc;
  logic hs, last;
  assign hs = prod_valid & prod_ready;
  assign last = hs && cnt == LEN_W'(1);
  assign acc_num = acc;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = start ? ACCUM : IDLE;
      ACCUM: next_state = last ? FLUSH : ACCUM;
      FLUSH: next_state = DONE;
      DONE:  next_state = acc_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    prod_ready = state == ACCUM;
    acc_valid = state == DONE;
    busy = state != IDLE;
  end
  // prod holds zero on bubbles so the one-edge-late add contributes nothing for them
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt <= '0;
      prod <= '0;
      acc <= '0;
    end else if (state == IDLE && start) begin
      cnt <= cfg_len;
      prod <= '0;
      acc <= '0;
    end else if (state == ACCUM || state == FLUSH) begin
      if (hs) cnt <= cnt - LEN_W'(1);
      prod <= hs ? C_NUM : '0;
      acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
    end
endmodule

// File: tb/tb_mult_accum_ctrl.sv
// tb_mult_accum_ctrl: randomized self-checking bench with an arithmetic-sum reference model
module tb_mult_accum_ctrl;
  import mult_accum_ctrl_pkg::*;
  localparam int LW = LEN_W_DEF;
  localparam int AW = ACC_W_DEF;
  logic sys_clk = 0, sys_rst = 1, start = 0, prod_valid = 0, acc_ready = 0;
  logic [LW-1:0] cfg_len = '0;
  logic [31:0] C_NUM = '0;
  logic prod_ready, acc_valid, busy;
  logic [AW-1:0] acc_num;
  int errors = 0, checks = 0;

  always #5 sys_clk = ~sys_clk;

  mult_accum_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cfg_len(cfg_len),
    .C_NUM(C_NUM), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_num(acc_num), .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy)
  );

  function automatic logic [AW-1:0] model_sum(input logic [31:0] q[$]);
    longint s = 0;
    foreach (q[i]) s += longint'($signed(q[i]));
    return AW'(s);
  endfunction

  task automatic burst(input int len, input logic [31:0] q[$], input int gap_max);
    @(negedge sys_clk);
    start = 1;
    cfg_len = LW'(len);
    @(negedge sys_clk);
    start = 0;
    foreach (q[i]) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge sys_clk);
      prod_valid = 1;
      C_NUM = q[i];
      @(negedge sys_clk);
      prod_valid = 0;
      C_NUM = $urandom;
    end
  endtask

  task automatic release_done();
    acc_ready = 1;
    @(negedge sys_clk);
    acc_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks += 4;
    if (acc_num !== '0) begin errors++; $display("FAIL reset_acc_num: got %h want 0", acc_num); end
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %b want 0", acc_valid); end
    if (prod_ready !== 1'b0) begin errors++; $display("FAIL reset_prod_ready: got %b want 0", prod_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    sys_rst = 0;
  endtask

  task automatic test_basic();
    logic [31:0] q[$];
    repeat (4) q.push_back(32'h4000_0000);
    burst(4, q, 0);
    checks += 5;
    if (acc_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_flush: valid %b busy %b want 0 1", acc_valid, busy); end
    @(negedge sys_clk);
    if (acc_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", acc_valid); end
    if (acc_num !== 40'h01_0000_0000) begin errors++; $display("FAIL basic_sum: got %h want 0100000000", acc_num); end
    if (acc_num !== model_sum(q)) begin errors++; $display("FAIL basic_model: got %h want %h", acc_num, model_sum(q)); end
    release_done();
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release: valid %b busy %b want 0 0", acc_valid, busy); end
  endtask

  task automatic test_bubbles();
    @(negedge sys_clk);
    start = 1;
    cfg_len = LW'(3);
    @(negedge sys_clk);
    start = 0;
    prod_valid = 1; C_NUM = 32'd100;
    @(negedge sys_clk);
    prod_valid = 0;
    repeat (2) @(negedge sys_clk);
    prod_valid = 1; C_NUM = -32'sd300;
    @(negedge sys_clk);
    prod_valid = 0;
    @(negedge sys_clk);
    checks += 4;
    if (prod_ready !== 1'b1) begin errors++; $display("FAIL bubbles_still_accum: got %b want 1", prod_ready); end
    prod_valid = 1; C_NUM = 32'd50;
    @(negedge sys_clk);
    prod_valid = 0;
    if (prod_ready !== 1'b0) begin errors++; $display("FAIL bubbles_flush: got %b want 0", prod_ready); end
    @(negedge sys_clk);
    if (acc_valid !== 1'b1) begin errors++; $display("FAIL bubbles_valid: got %b want 1", acc_valid); end
    if (acc_num !== 40'hFF_FFFF_FF6A) begin errors++; $display("FAIL bubbles_sum: got %h want ffffffff6a", acc_num); end
    release_done();
  endtask

  task automatic test_full_len();
    logic [31:0] q[$];
    repeat (256) q.push_back(32'h4000_0000);
    burst(0, q, 0);
    checks += 3;
    if (prod_ready !== 1'b0) begin errors++; $display("FAIL full_flush: got %b want 0", prod_ready); end
    @(negedge sys_clk);
    if (acc_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", acc_valid); end
    if (acc_num !== 40'h40_0000_0000) begin errors++; $display("FAIL full_sum: got %h want 4000000000", acc_num); end
    release_done();
  endtask

  task automatic test_hold();
    logic [31:0] q[$];
    logic [AW-1:0] exp;
    q.push_back($urandom);
    q.push_back($urandom);
    exp = model_sum(q);
    burst(2, q, 1);
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      start = i == 2;
      cfg_len = LW'(1);
      @(negedge sys_clk);
      start = 0;
      checks += 3;
      if (acc_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, acc_valid); end
      if (acc_num !== exp) begin errors++; $display("FAIL hold_sum[%0d]: got %h want %h", i, acc_num, exp); end
      if (prod_ready !== 1'b0) begin errors++; $display("FAIL hold_prod_ready[%0d]: got %b want 0", i, prod_ready); end
    end
    start = 1;
    release_done();
    start = 0;
    checks += 2;
    if (busy !== 1'b0 || acc_valid !== 1'b0) begin errors++; $display("FAIL hold_release: busy %b valid %b want 0 0", busy, acc_valid); end
    @(negedge sys_clk);
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] q[$];
    @(negedge sys_clk);
    start = 1;
    cfg_len = LW'(4);
    @(negedge sys_clk);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1; C_NUM = 32'h0123_4567;
      @(negedge sys_clk);
    end
    prod_valid = 0;
    #2 sys_rst = 1;
    #1;
    checks += 4;
    if (acc_num !== '0) begin errors++; $display("FAIL midrst_acc_num: got %h want 0", acc_num); end
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL midrst_acc_valid: got %b want 0", acc_valid); end
    if (prod_ready !== 1'b0) begin errors++; $display("FAIL midrst_prod_ready: got %b want 0", prod_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (2) @(negedge sys_clk);
    sys_rst = 0;
    q.push_back(32'h2E9D_DB04);
    burst(1, q, 0);
    @(negedge sys_clk);
    checks += 2;
    if (acc_valid !== 1'b1) begin errors++; $display("FAIL midrst_after_valid: got %b want 1", acc_valid); end
    if (acc_num !== 40'h00_2E9D_DB04) begin errors++; $display("FAIL midrst_after_sum: got %h want 002e9ddb04", acc_num); end
    release_done();
  endtask

  task automatic test_mult();
    logic signed [15:0] a, b;
    logic signed [31:0] p;
    logic [31:0] q[$];
    a = 16'sh92C2;
    b = 16'sh92C2;
    p = a * b;
    q.push_back(p);
    burst(1, q, 2);
    @(negedge sys_clk);
    checks += 2;
    if (acc_valid !== 1'b1) begin errors++; $display("FAIL mult_valid: got %b want 1", acc_valid); end
    if (acc_num !== 40'h00_2E9D_DB04) begin errors++; $display("FAIL mult_sum: got %h want 002e9ddb04", acc_num); end
    release_done();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [31:0] q[$];
      logic [AW-1:0] exp;
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) q.push_back($urandom);
      exp = model_sum(q);
      burst(len, q, 2);
      checks += 3;
      if (acc_valid !== 1'b0) begin errors++; $display("FAIL rand_flush[%0d]: got %b want 0", n, acc_valid); end
      @(negedge sys_clk);
      if (acc_valid !== 1'b1) begin errors++; $display("FAIL rand_valid[%0d]: got %b want 1", n, acc_valid); end
      repeat ($urandom_range(3, 0)) @(negedge sys_clk);
      if (acc_num !== exp) begin errors++; $display("FAIL rand_sum[%0d]: got %h want %h", n, acc_num, exp); end
      release_done();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_full_len();
    test_hold();
    test_mid_reset();
    test_mult();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
